sdp_ram_be: RTL and testbench

Single-clock simple dual-port RAM with per-byte write enables, selectable read latency, configurable read/write collision mode and a hardware clear engine that zeroes the array after reset or on request. It is the parametrised successor to the team's basic one-write/one-read memory. It serves as the storage primitive under FIFOs, descriptor tables and packet buffers that need deterministic post-reset contents.

---
 rtl/sdp_ram_be.sv | 158 +++++++++++++++
 tb/tb_sdp_ram_be.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_ram_be.sv
// rtl/sdp_ram_be.sv - simple dual-port RAM with byte enables, read pipeline and clear engine
module sdp_ram_be #(
   parameter int DATA_WIDTH     = 32,
   parameter int BYTE_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 8,
   parameter int RAM_DEPTH      = 1 << ADDR_WIDTH,
   parameter int RD_LATENCY     = 1,
   parameter bit BYPASS         = 1'b1,
   parameter bit CLEAR_ON_RESET = 1'b1,
   localparam int NUM_BYTES     = DATA_WIDTH / BYTE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [NUM_BYTES-1:0]  wbe,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rvalid,
   output logic                  init_busy
);

   typedef enum logic {READY = 1'b0, CLEAR = 1'b1} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(RAM_DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_W     = (ADDR_WIDTH + 1)'(RAM_DEPTH);
   localparam state_t                RESET_STATE = CLEAR_ON_RESET ? CLEAR : READY;

   state_t                state;
   logic [ADDR_WIDTH-1:0] clr_cnt;
   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

   logic                  wr_go;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [NUM_BYTES-1:0]  wr_be;
   logic                  wr_in_range;
   logic                  rd_go;
   logic                  rd_in_range;
   logic [DATA_WIDTH-1:0] rd_word;

   // The clear engine borrows the normal write port; user traffic is dropped meanwhile.
   always_comb begin
      if (state == READY) begin
         wr_go   = wr_en;
         wr_addr = waddr;
         wr_data = wdata;
         wr_be   = wbe;
      end else begin
         wr_go   = 1'b1;
         wr_addr = clr_cnt;
         wr_data = '0;
         wr_be   = '1;
      end
   end

   assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
   assign rd_in_range = ({1'b0, raddr} < DEPTH_W);
   assign rd_go       = (state == READY) && rd_en;

   always_ff @(posedge clk) begin
      if (wr_go && wr_in_range) begin
         for (int i = 0; i < NUM_BYTES; i++) begin
            if (wr_be[i]) begin
               mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   // Write-first forwarding works per lane so unwritten lanes still show stored data.
   always_comb begin
      rd_word = '0;
      if (rd_in_range) begin
         rd_word = mem[raddr];
         if (BYPASS && wr_go && wr_in_range && (wr_addr == raddr)) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
               if (wr_be[i]) begin
                  rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
               end
            end
         end
      end
   end

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic                  pipe_valid;
         logic [DATA_WIDTH-1:0] pipe_data;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pipe_valid <= 1'b0;
               pipe_data  <= '0;
               rvalid     <= 1'b0;
               rdata      <= '0;
            end else begin
               pipe_valid <= rd_go;
               if (rd_go) begin
                  pipe_data <= rd_word;
               end
               rvalid <= pipe_valid;
               if (pipe_valid) begin
                  rdata <= pipe_data;
               end
            end
         end
      end else begin : g_lat1
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rvalid <= 1'b0;
               rdata  <= '0;
            end else begin
               rvalid <= rd_go;
               if (rd_go) begin
                  rdata <= rd_word;
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RESET_STATE;
         clr_cnt   <= '0;
         init_busy <= CLEAR_ON_RESET;
      end else begin
         case (state)
            READY: begin
               if (clr) begin
                  state     <= CLEAR;
                  clr_cnt   <= '0;
                  init_busy <= 1'b1;
               end
            end
            CLEAR: begin
               if (clr_cnt == LAST_ADDR) begin
                  state     <= READY;
                  clr_cnt   <= '0;
                  init_busy <= 1'b0;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            default: begin
               state     <= READY;
               clr_cnt   <= '0;
               init_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdp_ram_be.sv
// tb/tb_sdp_ram_be.sv - checks four sdp_ram_be configurations against a behavioural model
module tb_sdp_ram_be;

   localparam int NI = 4;
   localparam int DEP [NI] = '{256, 256, 256, 200};
   localparam int LAT [NI] = '{1, 1, 2, 1};
   localparam bit BYP [NI] = '{1'b1, 1'b0, 1'b1, 1'b1};

   logic        clk;
   logic        rst_n;
   logic        clr;
   logic        wr_en;
   logic [7:0]  waddr;
   logic [31:0] wdata;
   logic [3:0]  wbe;
   logic        rd_en;
   logic [7:0]  raddr;
   logic [31:0] rdata_a  [NI];
   logic        rvalid_a [NI];
   logic        busy_a   [NI];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   bit [31:0] m_mem   [NI][256];
   bit        m_busy  [NI];
   int        m_cnt   [NI];
   bit [31:0] m_rdata [NI];
   bit        m_rv    [NI];
   bit [31:0] m_sd    [NI];
   bit        m_sv    [NI];

   logic [31:0] q2 [$];
   int          qc [$];

   sdp_ram_be #(.RD_LATENCY(1), .BYPASS(1'b1)) u_b1 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .waddr(waddr), .wdata(wdata),
      .wbe(wbe), .rd_en(rd_en), .raddr(raddr), .rdata(rdata_a[0]), .rvalid(rvalid_a[0]),
      .init_busy(busy_a[0]));

   sdp_ram_be #(.RD_LATENCY(1), .BYPASS(1'b0)) u_b0 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .waddr(waddr), .wdata(wdata),
      .wbe(wbe), .rd_en(rd_en), .raddr(raddr), .rdata(rdata_a[1]), .rvalid(rvalid_a[1]),
      .init_busy(busy_a[1]));

   sdp_ram_be #(.RD_LATENCY(2), .BYPASS(1'b1)) u_l2 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .waddr(waddr), .wdata(wdata),
      .wbe(wbe), .rd_en(rd_en), .raddr(raddr), .rdata(rdata_a[2]), .rvalid(rvalid_a[2]),
      .init_busy(busy_a[2]));

   sdp_ram_be #(.RAM_DEPTH(200)) u_d200 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .waddr(waddr), .wdata(wdata),
      .wbe(wbe), .rd_en(rd_en), .raddr(raddr), .rdata(rdata_a[3]), .rvalid(rvalid_a[3]),
      .init_busy(busy_a[3]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Model: one step per rising edge, asynchronous reset on rst_n falling.
   task automatic model_step();
      bit [31:0] rv;
      bit        busy0;
      bit        issue;
      for (int k = 0; k < NI; k++) begin
         if (!rst_n) begin
            m_busy[k]  = 1'b1;
            m_cnt[k]   = 0;
            m_rdata[k] = '0;
            m_rv[k]    = 1'b0;
            m_sd[k]    = '0;
            m_sv[k]    = 1'b0;
         end else begin
            busy0 = m_busy[k];
            issue = !busy0 && rd_en;
            rv    = (int'(raddr) < DEP[k]) ? m_mem[k][raddr] : 32'h0;
            if (issue && BYP[k] && wr_en && (waddr == raddr) && (int'(raddr) < DEP[k])) begin
               for (int b = 0; b < 4; b++) begin
                  if (wbe[b]) rv[b*8 +: 8] = wdata[b*8 +: 8];
               end
            end
            if (LAT[k] == 1) begin
               m_rv[k] = issue;
               if (issue) m_rdata[k] = rv;
            end else begin
               m_rv[k] = m_sv[k];
               if (m_sv[k]) m_rdata[k] = m_sd[k];
               m_sv[k] = issue;
               if (issue) m_sd[k] = rv;
            end
            if (busy0) begin
               m_mem[k][m_cnt[k][7:0]] = '0;
               m_cnt[k]++;
               if (m_cnt[k] == DEP[k]) m_busy[k] = 1'b0;
            end else begin
               if (wr_en && (int'(waddr) < DEP[k])) begin
                  for (int b = 0; b < 4; b++) begin
                     if (wbe[b]) m_mem[k][waddr][b*8 +: 8] = wdata[b*8 +: 8];
                  end
               end
               if (clr) begin
                  m_busy[k] = 1'b1;
                  m_cnt[k]  = 0;
               end
            end
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         model_step();
      end
   end

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         for (int k = 0; k < NI; k++) begin
            lit($sformatf("busy[%0d]", k), 32'(busy_a[k]), 32'(m_busy[k]));
            lit($sformatf("rvalid[%0d]", k), 32'(rvalid_a[k]), 32'(m_rv[k]));
            lit($sformatf("rdata[%0d]", k), rdata_a[k], m_rdata[k]);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rvalid_a[2]) begin
            q2.push_back(rdata_a[2]);
            qc.push_back(cyc);
         end
      end
   end

   task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
      wr_en = 1'b1; waddr = a; wdata = d; wbe = be;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic read_lit(input logic [7:0] a, input int k, input logic [31:0] exp, input string nm);
      rd_en = 1'b1; raddr = a;
      @(posedge clk); #1;
      rd_en = 1'b0;
      if (LAT[k] == 2) @(posedge clk);
      @(negedge clk);
      lit({nm, "_v"}, 32'(rvalid_a[k]), 32'd1);
      lit(nm, rdata_a[k], exp);
   endtask

   // Called at a falling edge; counts low-phase samples with init_busy high.
   task automatic count_busy(output int n0, output int n3, output bit saw_rv);
      n0 = 0; n3 = 0; saw_rv = 1'b0;
      for (int g = 0; g < 2000 && (busy_a[0] || busy_a[3]); g++) begin
         if (busy_a[0]) n0++;
         if (busy_a[3]) n3++;
         if (rvalid_a[0]) saw_rv = 1'b1;
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, n3, c0;
      bit saw;
      rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      waddr = '0; raddr = '0; wdata = '0; wbe = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      lit("rst_busy", 32'(busy_a[0]), 32'd1);
      lit("rst_rvalid", 32'(rvalid_a[0]), 32'd0);
      lit("rst_rdata", rdata_a[0], 32'h0);

      @(posedge clk); #1;
      rst_n = 1'b1;
      rd_en = 1'b1; raddr = 8'd4;
      @(negedge clk);
      count_busy(n0, n3, saw);
      rd_en = 1'b0;
      lit("init_busy_cycles", 32'(n0), 32'd256);
      lit("init_busy_cycles_d200", 32'(n3), 32'd200);
      lit("rvalid_while_busy", 32'(saw), 32'd0);

      read_lit(8'd0, 0, 32'h0, "cleared_a0");
      read_lit(8'd255, 0, 32'h0, "cleared_a255");
      read_lit(8'd128, 0, 32'h0, "cleared_a128");

      wr(8'd5, 32'h11223344, 4'b1111);
      wr(8'd5, 32'hAABBCCDD, 4'b0101);
      read_lit(8'd5, 0, 32'h11BB33DD, "byte_enable");
      wr(8'd5, 32'hFFFFFFFF, 4'b0000);
      read_lit(8'd5, 0, 32'h11BB33DD, "wbe_zero");

      wr(8'd9, 32'h01020304, 4'b1111);
      wr_en = 1'b1; waddr = 8'd9; wdata = 32'hF0F0F0F0; wbe = 4'b0011;
      rd_en = 1'b1; raddr = 8'd9;
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0;
      @(negedge clk);
      lit("coll_bypass", rdata_a[0], 32'h0102F0F0);
      lit("coll_readfirst", rdata_a[1], 32'h01020304);
      read_lit(8'd9, 1, 32'h0102F0F0, "coll_after");

      wr(8'd12, 32'hCAFE0001, 4'b1111);
      read_lit(8'd12, 1, 32'hCAFE0001, "wr_then_rd");

      for (int i = 0; i < 8; i++) wr(8'(i), 32'h10 + 32'(i), 4'b1111);
      q2.delete(); qc.delete();
      c0 = 0;
      for (int i = 0; i < 8; i++) begin
         rd_en = 1'b1; raddr = 8'(i);
         @(posedge clk); #1;
         if (i == 0) c0 = cyc;
      end
      rd_en = 1'b0;
      repeat (4) @(negedge clk);
      lit("lat2_count", 32'(q2.size()), 32'd8);
      if (q2.size() == 8) begin
         for (int i = 0; i < 8; i++) lit($sformatf("lat2_data%0d", i), q2[i], 32'h10 + 32'(i));
         lit("lat2_first_cycle", 32'(qc[0]), 32'(c0 + 1));
         lit("lat2_last_cycle", 32'(qc[7]), 32'(c0 + 8));
      end

      wr(8'd3, 32'h00000055, 4'b1111);
      clr = 1'b1; rd_en = 1'b1; raddr = 8'd3;
      @(posedge clk); #1;
      clr = 1'b0; rd_en = 1'b0;
      @(negedge clk);
      lit("clr_inflight_v", 32'(rvalid_a[0]), 32'd1);
      lit("clr_inflight", rdata_a[0], 32'h55);
      count_busy(n0, n3, saw);
      lit("clr_busy_cycles", 32'(n0), 32'd256);
      read_lit(8'd3, 0, 32'h0, "clr_a3");

      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      repeat (100) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      lit("mid_rst_busy", 32'(busy_a[0]), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      count_busy(n0, n3, saw);
      lit("restart_busy_cycles", 32'(n0), 32'd256);
      lit("restart_busy_d200", 32'(n3), 32'd200);

      wr(8'd250, 32'hDEADBEEF, 4'b1111);
      read_lit(8'd250, 3, 32'h0, "oor_read_d200");
      read_lit(8'd250, 0, 32'hDEADBEEF, "inrange_read_d256");

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
